// File: rtl/dataslot_cmd_initiator_if.sv
// Bridge-side signal bundle between the dataslot command initiator and
// core_bridge_cmd.
//   master : initiator side, drives strobes and command parameters,
//            observes ack/done/err
//   slave  : bridge side, observes strobes and parameters, drives ack/done/err
// Signals:
//   target_dataslot_read/write   level strobes, rising edge starts a command
//   target_dataslot_ack          high from command start to completion
//   target_dataslot_done         completion flag
//   target_dataslot_err[2:0]     result code, valid with done
//   target_dataslot_id/slotoffset/bridgeaddr/length   command parameters
interface dataslot_cmd_initiator_if;
  logic        target_dataslot_read;
  logic        target_dataslot_write;
  logic        target_dataslot_ack;
  logic        target_dataslot_done;
  logic [2:0]  target_dataslot_err;
  logic [15:0] target_dataslot_id;
  logic [31:0] target_dataslot_slotoffset;
  logic [31:0] target_dataslot_bridgeaddr;
  logic [31:0] target_dataslot_length;

  modport master (
    output target_dataslot_read,
    output target_dataslot_write,
    output target_dataslot_id,
    output target_dataslot_slotoffset,
    output target_dataslot_bridgeaddr,
    output target_dataslot_length,
    input  target_dataslot_ack,
    input  target_dataslot_done,
    input  target_dataslot_err
  );

  modport slave (
    input  target_dataslot_read,
    input  target_dataslot_write,
    input  target_dataslot_id,
    input  target_dataslot_slotoffset,
    input  target_dataslot_bridgeaddr,
    input  target_dataslot_length,
    output target_dataslot_ack,
    output target_dataslot_done,
    output target_dataslot_err
  );
endinterface

// File: rtl/dataslot_cmd_initiator.sv
// Core-side initiator for APF target dataslot read/write commands.
// Accepts a single-cycle req_read/req_write pulse, drives the matching
// strobe and registered parameters towards core_bridge_cmd, and tracks
// ack/done/err to completion. One command in flight; requests while busy
// (or in the completion cycle) are dropped.
// Ports:
//   clk_74a, reset_n          clock and asynchronous active-low reset
//   req_read, req_write       start pulses (read wins if both)
//   req_id/slotoffset/bridgeaddr/length   parameters sampled with req_*
//   busy                      command accepted and not yet completed
//   cmd_done                  1-cycle completion pulse
//   cmd_err[2:0]              result code, held until the next accept
//   bridge                    dataslot signals towards core_bridge_cmd
//
// state      | meaning
// S_IDLE     | waiting for a request
// S_ISSUE    | strobe high, waiting for ack (ACK_TIMEOUT guard)
// S_WAIT_DONE| strobe low, waiting for ack=0 && done=1 (DONE_TIMEOUT guard)
// S_FINISH   | cmd_done pulse, busy low, requests ignored
module dataslot_cmd_initiator #(
  parameter logic [31:0] ACK_TIMEOUT  = 32'd7425000,
  parameter logic [31:0] DONE_TIMEOUT = 32'd742500000
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [15:0] req_id,
  input  logic [31:0] req_slotoffset,
  input  logic [31:0] req_bridgeaddr,
  input  logic [31:0] req_length,
  output logic        busy,
  output logic        cmd_done,
  output logic [2:0]  cmd_err,
  dataslot_cmd_initiator_if.master bridge
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_FINISH    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        op_read_q, op_read_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  err_q, err_d;
  logic [15:0] id_q, id_d;
  logic [31:0] off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;

  logic [31:0] cnt_sat_inc;
  logic [32:0] cnt_plus1;
  logic        ack_limit;
  logic        done_limit;

  // The limit fires on the cycle whose count reaches the timeout, so a
  // state lasts exactly TIMEOUT cycles before abort.
  assign cnt_sat_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  assign cnt_plus1   = {1'b0, cnt_q} + 33'd1;
  assign ack_limit   = (cnt_plus1 >= {1'b0, ACK_TIMEOUT});
  assign done_limit  = (cnt_plus1 >= {1'b0, DONE_TIMEOUT});

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_read_q <= 1'b0;
      cnt_q     <= 32'd0;
      err_q     <= 3'd0;
      id_q      <= 16'd0;
      off_q     <= 32'd0;
      addr_q    <= 32'd0;
      len_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_read_q <= op_read_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      id_q      <= id_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_read_d = op_read_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    id_d      = id_q;
    off_d     = off_q;
    addr_d    = addr_q;
    len_d     = len_q;

    case (state_q)
      S_IDLE: begin
        if (req_read || req_write) begin
          state_d   = S_ISSUE;
          op_read_d = req_read;
          id_d      = req_id;
          off_d     = req_slotoffset;
          addr_d    = req_bridgeaddr;
          len_d     = req_length;
          err_d     = 3'd0;
          cnt_d     = 32'd0;
        end
      end
      S_ISSUE: begin
        // A late ack still wins over a coincident timeout.
        if (bridge.target_dataslot_ack) begin
          state_d = S_WAIT_DONE;
          cnt_d   = 32'd0;
        end else if (ack_limit) begin
          state_d = S_FINISH;
          err_d   = 3'h7;
        end else begin
          cnt_d = cnt_sat_inc;
        end
      end
      S_WAIT_DONE: begin
        // done while ack is still high belongs to the previous command.
        if (!bridge.target_dataslot_ack && bridge.target_dataslot_done) begin
          state_d = S_FINISH;
          err_d   = bridge.target_dataslot_err;
        end else if (done_limit) begin
          state_d = S_FINISH;
          err_d   = 3'h6;
        end else begin
          cnt_d = cnt_sat_inc;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register: they rise on ISSUE
  // entry, fall on ISSUE exit, and clear asynchronously with reset.
  assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
  assign cmd_done = (state_q == S_FINISH);
  assign cmd_err  = err_q;

  assign bridge.target_dataslot_read       = (state_q == S_ISSUE) &&  op_read_q;
  assign bridge.target_dataslot_write      = (state_q == S_ISSUE) && !op_read_q;
  assign bridge.target_dataslot_id         = id_q;
  assign bridge.target_dataslot_slotoffset = off_q;
  assign bridge.target_dataslot_bridgeaddr = addr_q;
  assign bridge.target_dataslot_length     = len_q;

endmodule

// File: tb/tb_dataslot_cmd_initiator.sv
// Bench for dataslot_cmd_initiator: a stimulus process issues commands and
// pushes expected outcomes, a reactive bridge model answers the strobes
// following a per-command plan, and a monitor checks strobes and
// completions against the expected queue.
module tb_dataslot_cmd_initiator;
  localparam int ACK_TO  = 16;
  localparam int DONE_TO = 40;
  localparam int N_RAND  = 36;
  localparam int M_NORMAL = 0;
  localparam int M_NOACK  = 1;
  localparam int M_NODONE = 2;

  typedef struct {
    bit          is_read;
    logic [15:0] id;
    logic [31:0] off;
    logic [31:0] addr;
    logic [31:0] len;
    logic [2:0]  err;
    int          mode;
    int          req_cyc;
  } exp_t;

  typedef struct {
    int          mode;
    int          ack_dly;
    int          stale;
    int          hold;
    int          gap;
    logic [2:0]  err;
  } plan_t;

  logic        clk_74a = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_id = '0;
  logic [31:0] req_slotoffset = '0;
  logic [31:0] req_bridgeaddr = '0;
  logic [31:0] req_length = '0;
  logic        busy;
  logic        cmd_done;
  logic [2:0]  cmd_err;

  dataslot_cmd_initiator_if bus ();

  dataslot_cmd_initiator #(
    .ACK_TIMEOUT (ACK_TO),
    .DONE_TIMEOUT(DONE_TO)
  ) dut (
    .clk_74a       (clk_74a),
    .reset_n       (reset_n),
    .req_read      (req_read),
    .req_write     (req_write),
    .req_id        (req_id),
    .req_slotoffset(req_slotoffset),
    .req_bridgeaddr(req_bridgeaddr),
    .req_length    (req_length),
    .busy          (busy),
    .cmd_done      (cmd_done),
    .cmd_err       (cmd_err),
    .bridge        (bus)
  );

  always #5 clk_74a = ~clk_74a;

  logic rd, wr;
  assign rd = bus.target_dataslot_read;
  assign wr = bus.target_dataslot_write;

  int cyc = 0;
  always @(posedge clk_74a) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  exp_t  exp_q[$];
  plan_t plan_q[$];
  bit    br_busy = 1'b0;
  bit    strobed = 1'b0;
  int    exp_done_cyc = 0;
  logic [2:0] last_err = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic plan_t mk_plan(input int mode, input int ack_dly, input int stale,
                                    input int hold, input int gap, input logic [2:0] err);
    plan_t p;
    p.mode = mode; p.ack_dly = ack_dly; p.stale = stale;
    p.hold = hold; p.gap = gap; p.err = err;
    return p;
  endfunction

  // Bridge model: answers each strobe according to the plan of the command.
  initial begin : bridge
    plan_t p;
    int a, hold_n;
    bus.target_dataslot_ack  = 1'b0;
    bus.target_dataslot_done = 1'b0;
    bus.target_dataslot_err  = 3'd0;
    forever begin
      @(negedge clk_74a);
      if (reset_n && (rd || wr) && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        br_busy = 1'b1;
        repeat (p.ack_dly) @(negedge clk_74a);
        if (p.mode == M_NOACK) begin
          for (int i = 0; i < 200 && (rd || wr); i++) @(negedge clk_74a);
        end else begin
          bus.target_dataslot_ack = 1'b1;
          a = cyc;
          if (p.mode == M_NODONE) exp_done_cyc = a + 1 + DONE_TO;
          hold_n = (p.mode == M_NODONE) ? 60 : p.hold;
          for (int i = 1; i <= hold_n; i++) begin
            @(negedge clk_74a);
            if (i == 1 && reset_n) chk("strobe_fall_after_ack", 32'({rd, wr}), 32'd0);
            if (i >= p.stale) bus.target_dataslot_done = 1'b0;
          end
          bus.target_dataslot_ack = 1'b0;
          if (p.mode == M_NORMAL) begin
            repeat (p.gap) @(negedge clk_74a);
            bus.target_dataslot_done = 1'b1;
            bus.target_dataslot_err  = p.err;
            exp_done_cyc = cyc + 1;
          end
        end
        br_busy = 1'b0;
      end
    end
  end

  // Monitor: strobe rises and completions against the expected queue.
  initial begin : monitor
    exp_t e;
    bit prv_rd, prv_wr;
    prv_rd = 1'b0; prv_wr = 1'b0;
    forever begin
      @(negedge clk_74a);
      if (!reset_n) begin
        prv_rd = 1'b0; prv_wr = 1'b0;
      end else begin
        chk("strobe_exclusive", 32'(rd & wr), 32'd0);
        if ((rd && !prv_rd) || (wr && !prv_wr)) begin
          chk("strobe_expected", 32'(exp_q.size() > 0 && !strobed), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            strobed = 1'b1;
            chk("strobe_rd", 32'(rd), 32'(e.is_read));
            chk("strobe_wr", 32'(wr), 32'(!e.is_read));
            chk("param_id", 32'(bus.target_dataslot_id), 32'(e.id));
            chk("param_off", bus.target_dataslot_slotoffset, e.off);
            chk("param_addr", bus.target_dataslot_bridgeaddr, e.addr);
            chk("param_len", bus.target_dataslot_length, e.len);
            chk("accept_latency", 32'(cyc), 32'(e.req_cyc + 1));
            chk("err_cleared_on_accept", 32'(cmd_err), 32'd0);
            chk("busy_with_strobe", 32'(busy), 32'd1);
            if (e.mode == M_NOACK) exp_done_cyc = cyc + ACK_TO;
          end
        end
        if (cmd_done) begin
          chk("done_has_cmd", 32'(exp_q.size() > 0 && strobed), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_err", 32'(cmd_err), 32'(e.err));
            chk("done_cycle", 32'(cyc), 32'(exp_done_cyc));
            chk("done_busy_low", 32'(busy), 32'd0);
            chk("done_strobes_low", 32'({rd, wr}), 32'd0);
            chk("done_param_id", 32'(bus.target_dataslot_id), 32'(e.id));
            chk("done_param_addr", bus.target_dataslot_bridgeaddr, e.addr);
            last_err = e.err;
          end
          strobed = 1'b0;
        end
        prv_rd = rd; prv_wr = wr;
      end
    end
  end

  // Waits for an idle DUT and bridge, pulsing ignored requests while busy
  // or in the completion cycle.
  task automatic wait_idle();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk_74a);
      req_read = 1'b0; req_write = 1'b0;
      if (!busy && !cmd_done && !br_busy && plan_q.size() == 0) return;
      if ((busy && $urandom_range(0, 3) == 0) || (cmd_done && $urandom_range(0, 1) == 0)) begin
        req_read       = 1'($urandom_range(0, 1));
        req_write      = !req_read || 1'($urandom_range(0, 1));
        req_id         = 16'($urandom_range(0, 65535));
        req_slotoffset = $urandom;
        req_bridgeaddr = $urandom;
        req_length     = $urandom;
      end
    end
    $display("FAIL wait_idle: timed out, busy=%0d br_busy=%0d", busy, br_busy);
    $fatal(1, "bench stalled");
  endtask

  // op: 0 read, 1 write, 2 both in the same cycle
  task automatic issue(input int op, input logic [15:0] id, input logic [31:0] off,
                       input logic [31:0] addr, input logic [31:0] len, input plan_t p);
    exp_t e;
    wait_idle();
    chk("err_held", 32'(cmd_err), 32'(last_err));
    req_read       = (op != 1);
    req_write      = (op != 0);
    req_id         = id;
    req_slotoffset = off;
    req_bridgeaddr = addr;
    req_length     = len;
    e.is_read = (op != 1);
    e.id = id; e.off = off; e.addr = addr; e.len = len;
    e.mode = p.mode;
    e.err = (p.mode == M_NOACK) ? 3'h7 : (p.mode == M_NODONE) ? 3'h6 : p.err;
    e.req_cyc = cyc;
    exp_q.push_back(e);
    plan_q.push_back(p);
    @(negedge clk_74a);
    req_read = 1'b0; req_write = 1'b0;
    req_id = '0; req_slotoffset = '0; req_bridgeaddr = '0; req_length = '0;
  endtask

  task automatic issue_random();
    plan_t p;
    int r, op, h;
    r  = $urandom_range(0, 5);
    op = (r < 3) ? 0 : (r < 5) ? 1 : 2;
    h  = $urandom_range(1, 8);
    r  = $urandom_range(0, 7);
    p  = mk_plan((r == 0) ? M_NOACK : (r == 1) ? M_NODONE : M_NORMAL,
                 $urandom_range(0, 10), $urandom_range(0, h), h,
                 $urandom_range(0, 8), 3'($urandom_range(0, 7)));
    issue(op, 16'($urandom_range(0, 65535)), $urandom, $urandom, $urandom, p);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit ok;
    int n_done;
    repeat (3) @(negedge clk_74a);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(cmd_done), 32'd0);
    chk("reset_err", 32'(cmd_err), 32'd0);
    chk("reset_strobes", 32'({rd, wr}), 32'd0);
    chk("reset_id", 32'(bus.target_dataslot_id), 32'd0);
    chk("reset_addr", bus.target_dataslot_bridgeaddr, 32'd0);
    reset_n = 1'b1;

    issue(0, 16'h0010, 32'd0, 32'h7000_0000, 32'h200, mk_plan(M_NORMAL, 3, 0, 2, 8, 3'd0));
    issue(1, 16'h0011, 32'h40, 32'h7000_1000, 32'h80, mk_plan(M_NORMAL, 1, 0, 3, 2, 3'd2));
    issue(2, 16'h0012, 32'h0, 32'h7000_2000, 32'h10, mk_plan(M_NORMAL, 0, 0, 1, 0, 3'd0));
    issue(1, 16'h0013, 32'h4, 32'h7000_3000, 32'h20, mk_plan(M_NOACK, 0, 0, 1, 0, 3'd0));
    // done is still high from the third command when this ack rises
    issue(0, 16'h0014, 32'h8, 32'h7000_4000, 32'h40, mk_plan(M_NORMAL, 2, 5, 5, 3, 3'd5));
    issue(0, 16'h0015, 32'hc, 32'h7000_5000, 32'h60, mk_plan(M_NODONE, 4, 0, 1, 0, 3'd0));
    issue(1, 16'h0016, 32'h10, 32'h7000_6000, 32'h70, mk_plan(M_NORMAL, 2, 1, 2, 1, 3'h7));

    for (int i = 0; i < N_RAND; i++) issue_random();

    issue(0, 16'h0020, 32'h100, 32'h7000_8000, 32'h100, mk_plan(M_NODONE, 2, 0, 1, 0, 3'd0));
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk_74a);
      if (busy && !rd && !wr) begin ok = 1'b1; break; end
    end
    chk("reach_wait_done", 32'(ok), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(cmd_done), 32'd0);
    chk("rst_strobes", 32'({rd, wr}), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_id", 32'(bus.target_dataslot_id), 32'd0);
    chk("rst_off", bus.target_dataslot_slotoffset, 32'd0);
    chk("rst_addr", bus.target_dataslot_bridgeaddr, 32'd0);
    chk("rst_len", bus.target_dataslot_length, 32'd0);
    exp_q.delete();
    strobed = 1'b0;
    last_err = 3'd0;
    n_done = 0;
    repeat (3) @(negedge clk_74a);
    #2 reset_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_74a);
      if (cmd_done) n_done++;
    end
    chk("no_done_after_reset", 32'(n_done), 32'd0);

    issue(0, 16'h0021, 32'h4, 32'h7000_9000, 32'h200, mk_plan(M_NORMAL, 2, 0, 2, 4, 3'd0));
    issue(1, 16'h0022, 32'h8, 32'h7000_a000, 32'h200, mk_plan(M_NORMAL, 5, 1, 3, 2, 3'd1));

    wait_idle();
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
